rgb2ycbcr_isp: RTL and testbench

Converts the camera's RGB565 pixel stream into 8-bit luma (and optionally Cb/Cr) using a fixed 3-stage multiply/add pipeline. It also tracks pixel position so downstream logic knows where each frame ends. It sits between the OV5640 capture/pixel-assembly logic and `sobel_isp`: its `y_wr_en`/`img_Y` drive `sobel_isp`'s `wr_en`/`img_Y`.

---
 rtl/isp_pkg.sv | 58 +++++
 rtl/rgb2ycbcr_isp_if.sv | 29 ++
 rtl/pix_pos_cnt.sv | 63 ++++++
 rtl/rgb2ycbcr_isp.sv | 134 +++++++++++++
 tb/tb_rgb2ycbcr_isp.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/isp_pkg.sv
`default_nettype none
// ============================================================================
// isp_pkg : constants and helpers shared by the camera ISP blocks
// Rev 1.0
// ============================================================================
package isp_pkg;

    localparam logic [7:0] COEF_Y_R  = 8'd77;
    localparam logic [7:0] COEF_Y_G  = 8'd150;
    localparam logic [7:0] COEF_Y_B  = 8'd29;
    localparam logic [7:0] COEF_CB_R = 8'd43;
    localparam logic [7:0] COEF_CB_G = 8'd85;
    localparam logic [7:0] COEF_CB_B = 8'd128;
    localparam logic [7:0] COEF_CR_R = 8'd128;
    localparam logic [7:0] COEF_CR_G = 8'd107;
    localparam logic [7:0] COEF_CR_B = 8'd21;

    localparam logic [16:0] CHROMA_OFS = 17'd32768;
    localparam int unsigned PIPE_LAT   = 3;

    localparam int unsigned RGB_R_MSB = 15;
    localparam int unsigned RGB_R_LSB = 11;
    localparam int unsigned RGB_G_MSB = 10;
    localparam int unsigned RGB_G_LSB = 5;
    localparam int unsigned RGB_B_MSB = 4;
    localparam int unsigned RGB_B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicating the field MSBs maps full-scale 565 codes onto exactly 255.
    function automatic rgb888_t rgb565_expand(input logic [15:0] pix);
        rgb888_t    o;
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5  = pix[RGB_R_MSB:RGB_R_LSB];
        g6  = pix[RGB_G_MSB:RGB_G_LSB];
        b5  = pix[RGB_B_MSB:RGB_B_LSB];
        o.r = {r5, r5[4:2]};
        o.g = {g6, g6[5:4]};
        o.b = {b5, b5[4:2]};
        return o;
    endfunction

    function automatic logic [15:0] cmul(input logic [7:0] coef, input logic [7:0] x);
        return {8'd0, coef} * {8'd0, x};
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2ycbcr_isp_if.sv
`default_nettype none
// ============================================================================
// rgb2ycbcr_isp_if : RGB565 pixel stream in, Y(CbCr) stream out
// Rev 1.0  (chroma signals present only with YCBCR_CHROMA_EN)
// ============================================================================
interface rgb2ycbcr_isp_if;
    logic        rgb_wr_en;
    logic [15:0] rgb_data;
    logic        y_wr_en;
    logic [7:0]  img_Y;
`ifdef YCBCR_CHROMA_EN
    logic [7:0]  img_Cb;
    logic [7:0]  img_Cr;
`endif
    logic        frame_done;

`ifdef YCBCR_CHROMA_EN
    modport master (output rgb_wr_en, rgb_data,
                    input  y_wr_en, img_Y, img_Cb, img_Cr, frame_done);
    modport slave  (input  rgb_wr_en, rgb_data,
                    output y_wr_en, img_Y, img_Cb, img_Cr, frame_done);
`else
    modport master (output rgb_wr_en, rgb_data,
                    input  y_wr_en, img_Y, frame_done);
    modport slave  (input  rgb_wr_en, rgb_data,
                    output y_wr_en, img_Y, frame_done);
`endif
endinterface
`default_nettype wire

// File: rtl/pix_pos_cnt.sv
`default_nettype none
// ============================================================================
// pix_pos_cnt : column/row tracker with end-of-frame pulse
// Rev 1.0
// ============================================================================
module pix_pos_cnt
    import isp_pkg::*;
#(
    parameter  int IMG_W = 640,
    parameter  int IMG_H = 480,
    localparam int COL_W = cnt_width(IMG_W),
    localparam int ROW_W = cnt_width(IMG_H)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             adv_i,
    input  logic             pre_vld_i,
    output logic [COL_W-1:0] col_cnt_o,
    output logic [ROW_W-1:0] row_cnt_o,
    output logic             frame_done_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic             frame_done_q, frame_done_d;

    // pre_vld_i marks the pixel that will be presented next cycle; its position
    // is the post-update count, so the registered pulse lands on that pixel.
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (adv_i) begin
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + ROW_W'(1);
            end else begin
                col_cnt_d = col_cnt_q + COL_W'(1);
            end
        end
        frame_done_d = pre_vld_i && (col_cnt_d == COL_LAST) && (row_cnt_d == ROW_LAST);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col_cnt_o    = col_cnt_q;
    assign row_cnt_o    = row_cnt_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: rtl/rgb2ycbcr_isp.sv
`default_nettype none
// ============================================================================
// rgb2ycbcr_isp : RGB565 -> 8-bit Y (Cb/Cr with YCBCR_CHROMA_EN), 3-stage pipe
// Rev 1.0
// ============================================================================
module rgb2ycbcr_isp
    import isp_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    rgb2ycbcr_isp_if.slave bus
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    rgb888_t             w_pix;
    logic [PIPE_LAT-1:0] vld_q;
    logic [15:0]         py_r_q, py_g_q, py_b_q;
    logic [16:0]         ys_q, ys_d;
    logic [7:0]          img_y_q;
    logic [COL_W-1:0]    w_col_cnt;
    logic [ROW_W-1:0]    w_row_cnt;
    logic                w_frame_done;
    logic                w_unused;

    assign w_pix = rgb565_expand(bus.rgb_data);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) vld_q <= '0;
        else            vld_q <= {vld_q[PIPE_LAT-2:0], bus.rgb_wr_en};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            py_r_q <= '0;
            py_g_q <= '0;
            py_b_q <= '0;
        end else if (bus.rgb_wr_en) begin
            py_r_q <= cmul(COEF_Y_R, w_pix.r);
            py_g_q <= cmul(COEF_Y_G, w_pix.g);
            py_b_q <= cmul(COEF_Y_B, w_pix.b);
        end
    end

    assign ys_d = {1'b0, py_r_q} + {1'b0, py_g_q} + {1'b0, py_b_q};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ys_q    <= '0;
            img_y_q <= '0;
        end else begin
            if (vld_q[0]) ys_q    <= ys_d;
            if (vld_q[1]) img_y_q <= ys_q[15:8];
        end
    end

    assign bus.y_wr_en = vld_q[PIPE_LAT-1];
    assign bus.img_Y   = img_y_q;

`ifdef YCBCR_CHROMA_EN
    logic [15:0] pcb_r_q, pcb_g_q, pcb_b_q;
    logic [15:0] pcr_r_q, pcr_g_q, pcr_b_q;
    logic [16:0] cbs_q, cbs_d, crs_q, crs_d;
    logic [7:0]  img_cb_q, img_cr_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcb_r_q <= '0;
            pcb_g_q <= '0;
            pcb_b_q <= '0;
            pcr_r_q <= '0;
            pcr_g_q <= '0;
            pcr_b_q <= '0;
        end else if (bus.rgb_wr_en) begin
            pcb_r_q <= cmul(COEF_CB_R, w_pix.r);
            pcb_g_q <= cmul(COEF_CB_G, w_pix.g);
            pcb_b_q <= cmul(COEF_CB_B, w_pix.b);
            pcr_r_q <= cmul(COEF_CR_R, w_pix.r);
            pcr_g_q <= cmul(COEF_CR_G, w_pix.g);
            pcr_b_q <= cmul(COEF_CR_B, w_pix.b);
        end
    end

    // Offset and positive term come first so no partial sum ever underflows.
    assign cbs_d = CHROMA_OFS + {1'b0, pcb_b_q} - {1'b0, pcb_r_q} - {1'b0, pcb_g_q};
    assign crs_d = CHROMA_OFS + {1'b0, pcr_r_q} - {1'b0, pcr_g_q} - {1'b0, pcr_b_q};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cbs_q    <= '0;
            crs_q    <= '0;
            img_cb_q <= '0;
            img_cr_q <= '0;
        end else begin
            if (vld_q[0]) begin
                cbs_q <= cbs_d;
                crs_q <= crs_d;
            end
            if (vld_q[1]) begin
                img_cb_q <= cbs_q[15:8];
                img_cr_q <= crs_q[15:8];
            end
        end
    end

    assign bus.img_Cb = img_cb_q;
    assign bus.img_Cr = img_cr_q;
    assign w_unused   = ^{ys_q[16], ys_q[7:0], cbs_q[16], cbs_q[7:0],
                          crs_q[16], crs_q[7:0], w_col_cnt, w_row_cnt};
`else
    assign w_unused   = ^{ys_q[16], ys_q[7:0], w_col_cnt, w_row_cnt};
`endif

    pix_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .adv_i        (vld_q[PIPE_LAT-1]),
        .pre_vld_i    (vld_q[PIPE_LAT-2]),
        .col_cnt_o    (w_col_cnt),
        .row_cnt_o    (w_row_cnt),
        .frame_done_o (w_frame_done)
    );

    assign bus.frame_done = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_rgb2ycbcr_isp.sv
`default_nettype none
// ============================================================================
// tb_rgb2ycbcr_isp : directed vector bench for rgb2ycbcr_isp (4x2 frame)
// Rev 1.0
// ============================================================================
module tb_rgb2ycbcr_isp;

    localparam int TB_W      = 4;
    localparam int TB_H      = 2;
    localparam int FRAME_PIX = TB_W * TB_H;
    localparam int NVEC      = 5;

    typedef struct packed {
        logic [15:0] rgb;
        logic [7:0]  y;
        logic [7:0]  cb;
        logic [7:0]  cr;
    } vec_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    always #5 sys_clk = ~sys_clk;

    rgb2ycbcr_isp_if bus ();

    rgb2ycbcr_isp #(
        .IMG_W (TB_W),
        .IMG_H (TB_H)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fd_seen;
    int          m_pos;
    logic        m_en  [3];
    logic [15:0] m_dat [3];
    logic [7:0]  exp_y;
`ifdef YCBCR_CHROMA_EN
    logic [7:0]  exp_cb, exp_cr;
`endif
    vec_t        vecs  [NVEC];

    function automatic int ex5(input logic [4:0] v);
        logic [7:0] e;
        e = {v, v[4:2]};
        return int'(e);
    endfunction

    function automatic int ex6(input logic [5:0] v);
        logic [7:0] e;
        e = {v, v[5:4]};
        return int'(e);
    endfunction

    function automatic logic [7:0] ref_y(input logic [15:0] p);
        int r, g, b;
        r = ex5(p[15:11]); g = ex6(p[10:5]); b = ex5(p[4:0]);
        return 8'((77 * r + 150 * g + 29 * b) / 256);
    endfunction

`ifdef YCBCR_CHROMA_EN
    function automatic logic [7:0] ref_cb(input logic [15:0] p);
        int r, g, b;
        r = ex5(p[15:11]); g = ex6(p[10:5]); b = ex5(p[4:0]);
        return 8'((32768 + 128 * b - 43 * r - 85 * g) / 256);
    endfunction

    function automatic logic [7:0] ref_cr(input logic [15:0] p);
        int r, g, b;
        r = ex5(p[15:11]); g = ex6(p[10:5]); b = ex5(p[4:0]);
        return 8'((32768 + 128 * r - 107 * g - 21 * b) / 256);
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            m_en[k]  = 1'b0;
            m_dat[k] = '0;
        end
        m_pos = 0;
        exp_y = '0;
`ifdef YCBCR_CHROMA_EN
        exp_cb = '0;
        exp_cr = '0;
`endif
    endtask

    // One clock: present a pixel, advance the model, compare all outputs.
    task automatic cycle(input logic en, input logic [15:0] d);
        logic fd_exp;
        bus.rgb_wr_en = en;
        bus.rgb_data  = d;
        @(posedge sys_clk);
        #1;
        for (int k = 2; k > 0; k--) begin
            m_en[k]  = m_en[k-1];
            m_dat[k] = m_dat[k-1];
        end
        m_en[0]  = en;
        m_dat[0] = d;
        fd_exp   = 1'b0;
        if (m_en[2]) begin
            exp_y  = ref_y(m_dat[2]);
`ifdef YCBCR_CHROMA_EN
            exp_cb = ref_cb(m_dat[2]);
            exp_cr = ref_cr(m_dat[2]);
`endif
            fd_exp = (m_pos == FRAME_PIX - 1);
            m_pos  = (m_pos + 1) % FRAME_PIX;
        end
        if (bus.frame_done === 1'b1) fd_seen++;
        check("y_wr_en",    32'(bus.y_wr_en),    32'(m_en[2]));
        check("img_Y",      32'(bus.img_Y),      32'(exp_y));
        check("frame_done", 32'(bus.frame_done), 32'(fd_exp));
`ifdef YCBCR_CHROMA_EN
        check("img_Cb",     32'(bus.img_Cb),     32'(exp_cb));
        check("img_Cr",     32'(bus.img_Cr),     32'(exp_cr));
`endif
    endtask

    task automatic do_reset();
        bus.rgb_wr_en = 1'b0;
        sys_rst_n     = 1'b0;
        #1;
        check("rst_y_wr_en",    32'(bus.y_wr_en),    32'd0);
        check("rst_img_Y",      32'(bus.img_Y),      32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
`ifdef YCBCR_CHROMA_EN
        check("rst_img_Cb",     32'(bus.img_Cb),     32'd0);
        check("rst_img_Cr",     32'(bus.img_Cr),     32'd0);
`endif
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        clear_model();
    endtask

    initial begin
        logic [15:0] d;
        vecs[0] = '{rgb: 16'hFFFF, y: 8'd255, cb: 8'd128, cr: 8'd128};
        vecs[1] = '{rgb: 16'h0000, y: 8'd0,   cb: 8'd128, cr: 8'd128};
        vecs[2] = '{rgb: 16'hF800, y: 8'd76,  cb: 8'd85,  cr: 8'd255};
        vecs[3] = '{rgb: 16'h07E0, y: 8'd149, cb: 8'd43,  cr: 8'd21};
        vecs[4] = '{rgb: 16'h001F, y: 8'd28,  cb: 8'd255, cr: 8'd107};
        bus.rgb_wr_en = 1'b0;
        bus.rgb_data  = '0;
        fd_seen       = 0;
        clear_model();
        #2;
        do_reset();

        // Isolated pixels: output is valid in the third cycle after presentation.
        for (int i = 0; i < NVEC; i++) begin
            cycle(1'b1, vecs[i].rgb);
            cycle(1'b0, 16'h0000);
            cycle(1'b0, 16'h0000);
            check("vec_valid", 32'(bus.y_wr_en), 32'd1);
            check("vec_Y",     32'(bus.img_Y),   32'(vecs[i].y));
`ifdef YCBCR_CHROMA_EN
            check("vec_Cb",    32'(bus.img_Cb),  32'(vecs[i].cb));
            check("vec_Cr",    32'(bus.img_Cr),  32'(vecs[i].cr));
`endif
            cycle(1'b0, 16'h0000);
        end

        // Alternating valid with a data ramp; outputs must hold across gaps.
        for (int k = 0; k < 12; k++) begin
            d = 16'(16'h1234 + k * 16'h0843);
            cycle((k % 2) == 0, d);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0000);

        // Two full 4x2 frames back to back.
        do_reset();
        fd_seen = 0;
        for (int k = 0; k < 2 * FRAME_PIX; k++) begin
            d = 16'(k * 16'h0841 + 16'h0003);
            cycle(1'b1, d);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0000);
        check("frame_pulses", 32'(fd_seen), 32'd2);
        check("col_wrap", 32'(dut.u_pos.col_cnt_q), 32'd0);
        check("row_wrap", 32'(dut.u_pos.row_cnt_q), 32'd0);

        // Reset with pixels in flight, then one clean frame.
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'hA5A5);
        do_reset();
        fd_seen = 0;
        for (int k = 0; k < FRAME_PIX; k++) begin
            d = 16'(16'h4210 + k * 16'h1111);
            cycle(1'b1, d);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0000);
        check("post_rst_pulses", 32'(fd_seen), 32'd1);

        // Full-scale then zero on consecutive cycles.
        cycle(1'b1, 16'hFFFF);
        cycle(1'b1, 16'h0000);
        cycle(1'b0, 16'h0000);
        check("b2b_first_valid", 32'(bus.y_wr_en), 32'd1);
        check("b2b_first_Y",     32'(bus.img_Y),   32'd255);
        cycle(1'b0, 16'h0000);
        check("b2b_second_valid", 32'(bus.y_wr_en), 32'd1);
        check("b2b_second_Y",     32'(bus.img_Y),   32'd0);
        cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
